// File: rtl/rising_edge_detector.sv
// Per-channel rising-edge detector: optional flop synchronizer, history register,
// and a registered one-cycle pulse for every 0->1 transition seen on each channel.
module rising_edge_detector #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic [WIDTH-1:0] sig,
  input  logic             clk,
  output logic [WIDTH-1:0] out,
  input  logic             rst_n
);

  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] r_prev;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign w_d = sig;
    end else begin : g_sync
      logic [WIDTH-1:0] r_sync [SYNC_STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int n = 0; n < SYNC_STAGES; n++) begin
            r_sync[n] <= '0;
          end
        end else begin
          r_sync[0] <= sig;
          for (int n = 1; n < SYNC_STAGES; n++) begin
            r_sync[n] <= r_sync[n-1];
          end
        end
      end

      assign w_d = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // prev clears on reset, so a channel already high at release reads as a fresh edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      out    <= '0;
    end else begin
      r_prev <= w_d;
      out    <= w_d & ~r_prev;
    end
  end

endmodule

// File: tb/tb_rising_edge_detector.sv
// Bench for rising_edge_detector: three instances (1ch/2 stages, 1ch/bypass, 8ch/2 stages)
// checked against a sample-history model plus fixed vectors and hand sequences.
module tb_rising_edge_detector;

  logic       clk;
  logic       rst_n;
  logic [0:0] sig0, out0;
  logic [0:0] sig1, out1;
  logic [7:0] sig2, out2;

  int total = 0;
  int bad   = 0;

  // Per-instance history of sampled inputs since last reset; index 0 is newest
  logic [7:0] h0[$];
  logic [7:0] h1[$];
  logic [7:0] h2[$];

  typedef struct {
    logic s;
    logic e;
  } vec_t;
  vec_t tbl[15];

  rising_edge_detector #(.WIDTH(1), .SYNC_STAGES(2)) u_d0 (
    .sig(sig0), .clk(clk), .out(out0), .rst_n(rst_n));
  rising_edge_detector #(.WIDTH(1), .SYNC_STAGES(0)) u_d1 (
    .sig(sig1), .clk(clk), .out(out1), .rst_n(rst_n));
  rising_edge_detector #(.WIDTH(8), .SYNC_STAGES(2)) u_d2 (
    .sig(sig2), .clk(clk), .out(out2), .rst_n(rst_n));

  initial begin
    clk = 1'b0;
    #5;
    forever begin
      clk = 1'b1;
      #10;
      clk = 1'b0;
      #10;
    end
  end

  // A rising edge is a sample of 1 whose preceding sample was 0 (zero before reset release);
  // it shows on the output SYNC_STAGES edges after the sampling edge.
  function automatic logic [7:0] mexp(input logic [7:0] q[$], input int s);
    logic [7:0] a;
    logic [7:0] b;
    a = (s < q.size()) ? q[s] : 8'h00;
    b = (s + 1 < q.size()) ? q[s+1] : 8'h00;
    return a & ~b;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  task automatic clear_model();
    h0.delete();
    h1.delete();
    h2.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      h0.push_front({7'b0, sig0});
      h1.push_front({7'b0, sig1});
      h2.push_front(sig2);
      if (h0.size() > 8) void'(h0.pop_back());
      if (h1.size() > 8) void'(h1.pop_back());
      if (h2.size() > 8) void'(h2.pop_back());
    end else begin
      clear_model();
    end
    #1;
    chk("model0", {7'b0, out0}, mexp(h0, 2) & 8'h01);
    chk("model1", {7'b0, out1}, mexp(h1, 0) & 8'h01);
    chk("model2", out2, mexp(h2, 2));
  endtask

  initial begin
    int first_hit;
    int pulses;
    bit seen;

    // single-channel, 2-stage vectors applied right after a clean reset release
    tbl[0]  = '{1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0};

    rst_n = 1'b0;
    sig0  = '0;
    sig1  = '0;
    sig2  = '0;
    clear_model();

    // held in reset with inputs toggling
    for (int i = 0; i < 5; i++) begin
      sig0 = 1'(i);
      sig1 = 1'(i + 1);
      sig2 = 8'($urandom);
      tick();
      chk("rst_hold", {6'b0, out1, out0} | out2, 8'h00);
    end

    sig0  = '0;
    sig1  = '0;
    sig2  = '0;
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      sig0 = tbl[i].s;
      tick();
      chk($sformatf("tbl[%0d]", i), {7'b0, out0}, {7'b0, tbl[i].e});
    end

    // bypass instance: 1,0,1 on consecutive edges
    sig1 = 1'b0;
    tick();
    tick();
    sig1 = 1'b1; tick(); chk("retrig_a", {7'b0, out1}, 8'h01);
    sig1 = 1'b0; tick(); chk("retrig_b", {7'b0, out1}, 8'h00);
    sig1 = 1'b1; tick(); chk("retrig_c", {7'b0, out1}, 8'h01);
    sig1 = 1'b0; tick(); chk("retrig_d", {7'b0, out1}, 8'h00);

    // eight channels rising together, then the complementary set
    sig2 = 8'h00;
    repeat (3) tick();
    sig2 = 8'hA5;
    tick(); chk("mc_lat0", out2, 8'h00);
    tick(); chk("mc_lat1", out2, 8'h00);
    tick(); chk("mc_a5", out2, 8'hA5);
    tick(); chk("mc_a5_end", out2, 8'h00);
    sig2 = 8'hFF;
    tick();
    tick();
    tick(); chk("mc_5a", out2, 8'h5A);
    tick(); chk("mc_5a_end", out2, 8'h00);

    // input already high across reset release
    rst_n = 1'b0;
    sig0  = 1'b1;
    tick();
    tick();
    rst_n     = 1'b1;
    first_hit = -1;
    pulses    = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out0 == 1'b1) begin
        pulses++;
        if (first_hit < 0) first_hit = i;
      end
    end
    chk("rel_pulses", 8'(pulses), 8'd1);
    chk("rel_edge", 8'(first_hit), 8'd2);

    // reset asserted while a pulse is high
    sig0 = 1'b0;
    repeat (3) tick();
    sig0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (out0 == 1'b1) seen = 1'b1;
    end
    chk("mid_seen", {7'b0, seen}, 8'h01);
    #4;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("mid_trunc", {7'b0, out0}, 8'h00);
    sig0 = 1'b0;
    tick();
    tick();
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out0 == 1'b1) pulses++;
    end
    chk("mid_noreplay", 8'(pulses), 8'd0);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      sig0  = 1'($urandom);
      sig1  = 1'($urandom);
      sig2  = 8'($urandom);
      rst_n = ($urandom_range(0, 39) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
